// File: rtl/mont_precompute.sv
// mont_precompute: bit-serial Montgomery operand prep; in base/exponent/modulo/valid_in, out base_mont/start_product/inv_modulo/R/exponent_out/modulo_out/valid_out/error_out/busy_out
module mont_precompute #(
  parameter int WIDTH = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulo,
  input  logic             valid_in,
  output logic [WIDTH-1:0] base_mont,
  output logic [WIDTH-1:0] start_product,
  output logic [WIDTH-1:0] inv_modulo,
  output logic [WIDTH:0]   R,
  output logic [WIDTH-1:0] exponent_out,
  output logic [WIDTH-1:0] modulo_out,
  output logic             valid_out,
  output logic             error_out,
  output logic             busy_out
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, REDUCE, SCALE, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, hi;
  logic [WIDTH-1:0] b, e, m, r, s, inv, t, r_n, s_n;
  logic [WIDTH:0] r2, s2;
  logic last, start, step;
  assign R = {1'b1, {WIDTH{1'b0}}};
  assign busy_out = state != IDLE;
  assign last = cnt == LAST;
  assign start = state == IDLE && valid_in && modulo[0];
  assign r2 = state == REDUCE ? {r, b[WIDTH-1]} : {r, 1'b0};
  assign s2 = {s, 1'b0};
  assign r_n = r2 >= {1'b0, m} ? WIDTH'(r2 - {1'b0, m}) : r2[WIDTH-1:0];
  assign s_n = s2 >= {1'b0, m} ? WIDTH'(s2 - {1'b0, m}) : s2[WIDTH-1:0];
  assign hi = cnt + 1'b1;
  assign step = !last && t[hi];
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? REDUCE : IDLE;
      REDUCE:  state_n = last ? SCALE : REDUCE;
      SCALE:   state_n = last ? DONE : SCALE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      {b, e, m, r, s, inv, t, cnt} <= '0;
      {base_mont, start_product, inv_modulo, exponent_out, modulo_out} <= '0;
      valid_out <= 1'b0;
      error_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      error_out <= state == IDLE && valid_in && !modulo[0];
      if (start) begin
        b <= base;
        e <= exponent;
        m <= modulo;
        r <= '0;
        s <= modulo == WIDTH'(1) ? '0 : WIDTH'(1);
        inv <= WIDTH'(1);
        t <= modulo;
        cnt <= '0;
      end
      if (state == REDUCE || state == SCALE) begin
        cnt <= last ? '0 : cnt + 1'b1;
        r <= r_n;
      end
      if (state == REDUCE) begin
        b <= b << 1;
        inv <= step ? inv | (WIDTH'(1) << hi) : inv;
        t <= step ? t + (m << hi) : t;
      end
      if (state == SCALE) begin
        s <= s_n;
        if (last) begin
          base_mont <= r_n;
          start_product <= s_n;
          inv_modulo <= inv;
          exponent_out <= e;
          modulo_out <= m;
          valid_out <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mont_precompute.sv
// tb_mont_precompute: directed and randomized checks of mont_precompute
module tb_mont_precompute;
  logic clk = 0, rst = 1, valid_in = 0;
  logic [15:0] base = 0, exponent = 0, modulo = 0;
  logic [15:0] base_mont, start_product, inv_modulo, exponent_out, modulo_out;
  logic [16:0] r_const;
  logic valid_out, error_out, busy_out;
  int checks = 0, failures = 0;
  mont_precompute #(.WIDTH(16)) dut (
    .clk_in(clk), .rst_in(rst), .base(base), .exponent(exponent), .modulo(modulo),
    .valid_in(valid_in), .base_mont(base_mont), .start_product(start_product),
    .inv_modulo(inv_modulo), .R(r_const), .exponent_out(exponent_out),
    .modulo_out(modulo_out), .valid_out(valid_out), .error_out(error_out), .busy_out(busy_out)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [15:0] mont_of(input logic [15:0] x, input logic [15:0] mm);
    logic [63:0] v;
    v = {48'd0, x} * 64'd65536 % {48'd0, mm};
    return v[15:0];
  endfunction
  function automatic logic [15:0] inv_of(input logic [15:0] mm);
    logic [15:0] x;
    x = mm;
    repeat (4) x = x * (16'd2 - mm * x);
    return x;
  endfunction
  task automatic run_job(input logic [15:0] bb, input logic [15:0] ee, input logic [15:0] mm, output int lat);
    base = bb;
    exponent = ee;
    modulo = mm;
    valid_in = 1;
    tick();
    valid_in = 0;
    lat = 1;
    while (!valid_out && lat < 100) begin
      tick();
      lat++;
    end
  endtask
  task automatic expect_job(input string tag, input logic [15:0] bb, input logic [15:0] ee, input logic [15:0] mm,
                            input logic [15:0] bm, input logic [15:0] sp, input logic [15:0] iv);
    int lat;
    run_job(bb, ee, mm, lat);
    check({tag, "_latency"}, lat, 33);
    check({tag, "_base_mont"}, base_mont, bm);
    check({tag, "_start_product"}, start_product, sp);
    check({tag, "_inv_modulo"}, inv_modulo, iv);
    check({tag, "_exponent_out"}, exponent_out, ee);
    check({tag, "_modulo_out"}, modulo_out, mm);
    check({tag, "_busy_done"}, busy_out, 1);
    tick();
    check({tag, "_pulse_width"}, valid_out, 0);
    check({tag, "_busy_idle"}, busy_out, 0);
  endtask
  initial begin
    int lat, pulses;
    logic [15:0] bb, ee, mm, bm_seen;
    #12;
    check("reset_base_mont", base_mont, 0);
    check("reset_start_product", start_product, 0);
    check("reset_inv_modulo", inv_modulo, 0);
    check("reset_R", r_const, 65536);
    check("reset_valid", valid_out, 0);
    check("reset_busy", busy_out, 0);
    rst = 0;
    tick();
    expect_job("t69_61", 16'd69, 16'd8, 16'd61, 16'd54, 16'd22, 16'd38677);
    check("R_const", r_const, 65536);
    expect_job("t_ffff_3", 16'd65535, 16'd1, 16'd3, 16'd0, 16'd1, 16'd43691);
    expect_job("t5_ffff", 16'd5, 16'd2, 16'd65535, 16'd5, 16'd1, 16'd65535);
    base = 16'd9;
    modulo = 16'd60;
    valid_in = 1;
    tick();
    valid_in = 0;
    check("even_error", error_out, 1);
    check("even_busy", busy_out, 0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i == 0) check("even_error_width", error_out, 0);
      if (valid_out || busy_out) pulses++;
    end
    check("even_no_job", pulses, 0);
    check("even_hold_base_mont", base_mont, 5);
    check("even_hold_modulo_out", modulo_out, 16'd65535);
    expect_job("t7_1", 16'd7, 16'd3, 16'd1, 16'd0, 16'd0, 16'd1);
    base = 16'd69;
    exponent = 16'd8;
    modulo = 16'd61;
    valid_in = 1;
    tick();
    valid_in = 0;
    pulses = 0;
    bm_seen = 0;
    for (int i = 1; i < 80; i++) begin
      if (i == 10) begin
        base = 16'd2;
        modulo = 16'd5;
        valid_in = 1;
      end
      if (i == 11) valid_in = 0;
      if (valid_out) begin
        pulses++;
        bm_seen = base_mont;
      end
      tick();
    end
    check("overlap_pulses", pulses, 1);
    check("overlap_base_mont", bm_seen, 54);
    check("overlap_modulo_out", modulo_out, 61);
    expect_job("t2_5", 16'd2, 16'd0, 16'd5, 16'd2, 16'd1, 16'd52429);
    base = 16'd100;
    modulo = 16'd77;
    valid_in = 1;
    tick();
    valid_in = 0;
    repeat (20) tick();
    #2 rst = 1;
    #1;
    check("abort_base_mont", base_mont, 0);
    check("abort_inv_modulo", inv_modulo, 0);
    check("abort_busy", busy_out, 0);
    check("abort_valid", valid_out, 0);
    tick();
    rst = 0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (valid_out) pulses++;
    end
    check("abort_no_valid", pulses, 0);
    expect_job("after_abort", 16'd100, 16'd4, 16'd77, mont_of(16'd100, 16'd77), mont_of(16'd1, 16'd77), inv_of(16'd77));
    for (int j = 0; j < 200; j++) begin
      bb = 16'($urandom);
      ee = 16'($urandom);
      mm = 16'($urandom) | 16'd1;
      run_job(bb, ee, mm, lat);
      check("rand_latency", lat, 33);
      check("rand_base_mont", base_mont, mont_of(bb, mm));
      check("rand_start_product", start_product, mont_of(16'd1, mm));
      check("rand_inv_modulo", inv_modulo, inv_of(mm));
      check("rand_inv_identity", 16'(modulo_out * inv_modulo), 1);
      check("rand_exponent_out", exponent_out, ee);
      check("rand_modulo_out", modulo_out, mm);
      tick();
      check("rand_pulse_width", valid_out, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mont_precompute.md
Name: mont_precompute

Overview:
- Upstream stage of mod_exponent. Converts a raw exponentiation job (base, exponent, odd modulo) into the Montgomery-domain operands that mod_exponent consumes: base_mont = (base*R) mod m, start_product = R mod m, inv_modulo = m^-1 mod R, and R = 2^WIDTH.
- Uses a bit-serial datapath with no multipliers. On completion it pulses valid_out, which is wired directly to mod_exponent valid_in.

Parameters:
- WIDTH, 16, operand width. R = 2^WIDTH.

Ports:
- clk_in, input, 1, clock.
- rst_in, input, 1, reset, asynchronous, active-high.
- base, input, WIDTH, raw base. Any value; may be >= modulo.
- exponent, input, WIDTH, exponent, passed through unchanged.
- modulo, input, WIDTH, modulus m. Must be odd.
- valid_in, input, 1, job strobe. Sampled only in IDLE.
- base_mont, output, WIDTH, (base*R) mod m.
- start_product, output, WIDTH, R mod m.
- inv_modulo, output, WIDTH, m^-1 mod 2^WIDTH.
- R, output, WIDTH+1, constant 2^WIDTH.
- exponent_out, output, WIDTH, registered exponent.
- modulo_out, output, WIDTH, registered modulo.
- valid_out, output, 1, one-cycle pulse: outputs are valid.
- error_out, output, 1, one-cycle pulse: even modulo rejected.
- busy_out, output, 1, high while a job is in progress.

Behaviour:
- Reset (async, any state): state=IDLE. All outputs 0 except R, which is 2^WIDTH at all times.
- States:
  - IDLE -> REDUCE when valid_in=1 and modulo[0]=1. Capture base, exponent and modulo on the same edge.
  - IDLE with valid_in=1 and modulo[0]=0 (includes 0): error_out=1 for exactly the next cycle. State stays IDLE. Data outputs unchanged; no valid_out.
  - REDUCE, exactly WIDTH cycles: r = base mod m, computed MSB-first as r = 2r + bit, then subtract m if r >= m. r starts at 0. Intermediate 2r+bit is held in WIDTH+1 bits.
  - Concurrent with REDUCE, Hensel inverse: inv=1, t=m. Step i runs 1..WIDTH-1; if t[i]=1 then inv[i]=1 and t = (t + (m<<i)) mod 2^WIDTH. WIDTH-1 steps; the last REDUCE cycle idles this unit.
  - SCALE, exactly WIDTH cycles, two doubling chains in parallel:
    - r = 2r, subtract m if r >= m.
    - s = 2s, subtract m if s >= m. s starts at (m==1 ? 0 : 1).
    - Both chains use WIDTH+1-bit intermediates.
  - DONE, 1 cycle: base_mont=r, start_product=s, inv_modulo=inv, exponent_out and modulo_out take the captured values, valid_out=1. Next state is IDLE.
- Latency: with the capture edge in cycle 0, valid_out is high in cycle 2*WIDTH+1. Outputs then hold until the next DONE or reset.
- busy_out: 1 in REDUCE, SCALE and DONE; 0 in IDLE.
- valid_in while busy_out=1 is ignored (dropped, not queued). valid_in held high across DONE starts a new job on the first IDLE cycle.
- m=1 is legal: base_mont=0, start_product=0, inv_modulo=1.
- Reset mid-job: the job is aborted and no valid_out is produced. The next valid_in after reset release starts normally.
- Inputs may change freely after the capture edge; only captured copies are used.
- Invariants: r < m and s < m at the end of every REDUCE/SCALE cycle. (m * inv_modulo) mod 2^WIDTH == 1.

Test Plan:
- WIDTH=16, base=69, exponent=8, modulo=61, 1-cycle valid_in -> valid_out in cycle 33. base_mont=54, start_product=22, inv_modulo=38677, R=65536, exponent_out=8, modulo_out=61. Chaining into mod_exponent yields c_out=20.
- base=65535, modulo=3 -> base_mont=0, start_product=1, inv_modulo=43691. base=5, modulo=65535 -> base_mont=5, start_product=1, inv_modulo=65535.
- modulo=60, valid_in=1 -> error_out high for 1 cycle, busy_out stays 0, no valid_out, prior outputs unchanged. modulo=1, base=7 -> valid_out with base_mont=0, start_product=0, inv_modulo=1.
- Second valid_in (base=2, modulo=5) pulsed in cycle 10 of a running job -> ignored; only one valid_out with the first job's results. Then base=2, modulo=5 issued from IDLE -> base_mont=2, start_product=1, inv_modulo=52429.
- rst_in asserted asynchronously mid-SCALE -> outputs 0, busy_out 0, no valid_out. A new job then completes in exactly 2*WIDTH+1 cycles with correct values.
- Randomized odd moduli (200 jobs) -> compare all outputs against a reference model. Check (modulo*inv_modulo) mod 65536 == 1 and that the valid_out pulse is exactly 1 cycle wide.
